scan_slot_arbiter: RTL and testbench
====================================

Name: scan_slot_arbiter

Overview:
- Round-robin scan arbiter sharing one resource among N requesters, built on a scanning slot counter with one-hot slot decode.
- The pointer walks slots 0..N-1 while enabled. When the current slot's request is set, the arbiter grants that slot and holds the grant until release or hold timeout, then resumes scanning at the next slot.
- Sits between the requester bank and the shared datapath. It sequences which C-type input the datapath samples.

Parameters:
N, 16, number of requesters/slots
PTR_W, 4, pointer width; must satisfy 2**PTR_W >= N
MAX_HOLD, 15, maximum grant length in cycles (>=1)

Ports:
CK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
EN  input  1  scan enable; gates pointer advance only
REQ  input  N  per-slot request, level
GNT  output  N  one-hot grant, registered
GNT_VALID  output  1  OR of GNT, registered
GNT_ID  output  PTR_W  index of granted slot; 0 when no grant
BUSY  output  1  state != IDLE
TIMEOUT  output  1  one-cycle pulse when a grant is forcibly ended

Behaviour:
- Reset (async, any state, mid-grant included):
  - state=IDLE, ptr=0, hold=0.
  - GNT=0, GNT_VALID=0, GNT_ID=0, BUSY=0, TIMEOUT=0.
  - All outputs are registered; there are no combinational input-to-output paths.
- FSM states: IDLE, SCAN, GRANT, RELEASE.
- IDLE:
  - If REQ!=0 and EN=1, go to SCAN.
  - Otherwise stay in IDLE; ptr holds.
- SCAN, per cycle:
  - EN=0: hold ptr and state.
  - EN=1 and REQ[ptr]=1: go to GRANT. Set GNT=1<<ptr, GNT_VALID=1, GNT_ID=ptr, hold=1.
  - EN=1 and REQ[ptr]=0: ptr<=ptr+1, wrapping from N-1 to 0 (not 2**PTR_W-1 when N<2**PTR_W).
  - REQ==0 with EN=1: return to IDLE; ptr keeps its value (no reset to 0).
- GRANT:
  - GNT stays stable; EN is ignored.
  - REQ[ptr]=0: go to RELEASE (normal release).
  - REQ[ptr]=1 and hold==MAX_HOLD: go to RELEASE and set TIMEOUT=1 for that RELEASE cycle.
  - Otherwise hold<=hold+1 (saturating counter of width clog2(MAX_HOLD+1)).
  - Requests on other slots do not preempt.
- RELEASE, exactly one cycle:
  - GNT=0, GNT_VALID=0, GNT_ID=0.
  - ptr<=ptr+1 with wrap.
  - Next state is SCAN if REQ!=0, else IDLE. TIMEOUT clears on exit.
- Latency:
  - From IDLE with ptr=p, a request on slot k is granted after 1 + ((k-p) mod N) + 1 rising edges (EN held high).
  - Worst case N+1 edges.
- Fairness: every slot is visited at most once between two grants to the same slot, so a continuously requesting slot waits at most (N-1)*(MAX_HOLD+1)+N cycles.
- Simultaneous events:
  - Request drop on the same edge hold reaches MAX_HOLD is a normal release; TIMEOUT=0.
  - REQ[ptr] rising while EN=0 in SCAN: no grant until EN=1.
- GNT is one-hot or zero at all times, and GNT_ID is consistent with GNT. The bench checks this with assertions.

Test Plan:
- Reset, EN=1, REQ=16'h0020 held → BUSY=1 after edge 1; GNT=16'h0020, GNT_ID=5 after edge 7; REQ drops → next edge GNT=0 (RELEASE), ptr=6, then IDLE.
- MAX_HOLD=4, REQ=16'h0008 held indefinitely → GNT[3] high exactly 4 cycles, TIMEOUT=1 for the following single cycle, regrant on slot 3 after a 16-slot rescan (N+1 edges after RELEASE).
- MAX_HOLD=4, REQ=16'h0208 held → grants alternate slot 3, slot 9, slot 3…; gap between slot-3 grant end and slot-9 grant start = 7 edges.
- Scan with EN toggling 1,0,0,1 while REQ=16'h8000 → ptr advances only on EN=1 cycles; GNT[15] later by exactly the number of EN=0 cycles; wrap 15→0 is checked next.
- Assert RST asynchronously between edges during GRANT → GNT, GNT_VALID, BUSY go 0 immediately without a clock edge; after release, scanning restarts at ptr=0.
- Random REQ/EN for 10k cycles → GNT one-hot-or-zero, no slot starved beyond the fairness bound, TIMEOUT only when hold reached MAX_HOLD.

Source files
------------

// File: rtl/scan_slot_arbiter.sv
// Round-robin scan arbiter: a slot pointer walks 0..N-1 and grants the first
// requesting slot it lands on, holding the grant until release or hold timeout.
module scan_slot_arbiter #(
    parameter int N        = 16,
    parameter int PTR_W    = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             EN,
    input  logic [N-1:0]     REQ,
    output logic [N-1:0]     GNT,
    output logic             GNT_VALID,
    output logic [PTR_W-1:0] GNT_ID,
    output logic             BUSY,
    output logic             TIMEOUT
);

    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GRANT,
        RELEASE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic [N-1:0]      gnt_nxt;
    logic              gnt_valid_nxt;
    logic [PTR_W-1:0]  gnt_id_nxt;
    logic              timeout_nxt;
    logic              busy_nxt;
    logic [N-1:0]      slot_sel;
    logic              req_any;
    logic              req_cur;

    // Wraps at N-1 rather than at 2**PTR_W-1 so non-power-of-two N never
    // lands on a slot that does not exist.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        slot_sel = '0;
        for (int i = 0; i < N; i++) begin
            slot_sel[i] = (ptr == PTR_W'(i));
        end
    end

    assign req_any = |REQ;
    assign req_cur = |(REQ & slot_sel);

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        hold_nxt      = hold;
        gnt_nxt       = GNT;
        gnt_valid_nxt = GNT_VALID;
        gnt_id_nxt    = GNT_ID;
        timeout_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (EN && req_any) begin
                    state_nxt = SCAN;
                end
            end

            SCAN: begin
                if (EN) begin
                    if (!req_any) begin
                        state_nxt = IDLE;
                    end else if (req_cur) begin
                        state_nxt     = GRANT;
                        gnt_nxt       = slot_sel;
                        gnt_valid_nxt = 1'b1;
                        gnt_id_nxt    = ptr;
                        hold_nxt      = HOLD_ONE;
                    end else begin
                        ptr_nxt = ptr_inc(ptr);
                    end
                end
            end

            // EN and requests on other slots are deliberately ignored here.
            GRANT: begin
                if (!req_cur || (hold == HOLD_MAX)) begin
                    state_nxt     = RELEASE;
                    gnt_nxt       = '0;
                    gnt_valid_nxt = 1'b0;
                    gnt_id_nxt    = '0;
                    timeout_nxt   = req_cur;
                end else begin
                    hold_nxt = hold + HOLD_ONE;
                end
            end

            RELEASE: begin
                ptr_nxt   = ptr_inc(ptr);
                hold_nxt  = '0;
                state_nxt = req_any ? SCAN : IDLE;
            end

            default: begin
                state_nxt     = IDLE;
                gnt_nxt       = '0;
                gnt_valid_nxt = 1'b0;
                gnt_id_nxt    = '0;
            end
        endcase
    end

    assign busy_nxt = (state_nxt != IDLE);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            ptr       <= '0;
            hold      <= '0;
            GNT       <= '0;
            GNT_VALID <= 1'b0;
            GNT_ID    <= '0;
            BUSY      <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold      <= hold_nxt;
            GNT       <= gnt_nxt;
            GNT_VALID <= gnt_valid_nxt;
            GNT_ID    <= gnt_id_nxt;
            BUSY      <= busy_nxt;
            TIMEOUT   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_scan_slot_arbiter.sv
// Self-checking bench for scan_slot_arbiter: directed latency/timeout/reset
// scenarios with an expected-grant queue, plus a long random run.
`timescale 1ns/1ps
module tb_scan_slot_arbiter;

    localparam int N          = 16;
    localparam int PTR_W      = 4;
    localparam int MAX_HOLD   = 4;
    localparam int FAIR_BOUND = (N - 1) * (MAX_HOLD + 1) + N;
    localparam logic [N-1:0] ONE = 1;

    logic             CK = 1'b0;
    logic             RST = 1'b0;
    logic             EN = 1'b0;
    logic [N-1:0]     REQ = '0;
    logic [N-1:0]     GNT;
    logic             GNT_VALID;
    logic [PTR_W-1:0] GNT_ID;
    logic             BUSY;
    logic             TIMEOUT;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int id;
        int edges;
        int held;
        bit tmo;
    } exp_t;

    exp_t exp_q[$];

    scan_slot_arbiter #(.N(N), .PTR_W(PTR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .CK(CK), .RST(RST), .EN(EN), .REQ(REQ), .GNT(GNT), .GNT_VALID(GNT_VALID),
        .GNT_ID(GNT_ID), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CK = ~CK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Grant must be one-hot or zero, with GNT_VALID and GNT_ID consistent.
    always @(negedge CK) begin
        if (!RST) begin
            checks++;
            assert (((GNT & (GNT - ONE)) == '0) && (GNT_VALID == (|GNT)) &&
                    ((GNT == '0) ? (GNT_ID == '0) : (GNT == (ONE << GNT_ID))))
            else begin
                errors++;
                $display("FAIL onehot: GNT=%h GNT_VALID=%b GNT_ID=%0d", GNT, GNT_VALID, GNT_ID);
            end
        end
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        REQ = '0;
        EN  = 1'b0;
        RST = 1'b1;
        tick();
        tick();
        #2 RST = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (GNT_VALID === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (GNT_VALID === 1'b0) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3 RST = 1'b1;
        #1;
        checks++; if (GNT !== '0) begin errors++; $display("FAIL reset_gnt: got %h want 0", GNT); end
        checks++; if (GNT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", GNT_VALID); end
        checks++; if (GNT_ID !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", GNT_ID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", TIMEOUT); end
        EN  = 1'b1;
        REQ = 16'hffff;
        tick();
        tick();
        checks++; if (BUSY !== 1'b0 || GNT_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_held: got busy=%b valid=%b want 0/0", BUSY, GNT_VALID);
        end
        REQ = '0;
        EN  = 1'b0;
        #2 RST = 1'b0;
    endtask

    task automatic test_basic_grant();
        exp_t x;
        int e;
        do_reset();
        EN  = 1'b1;
        REQ = 16'h0020;
        exp_q.push_back('{id: 5, edges: 7, held: 0, tmo: 1'b0});
        exp_q.push_back('{id: 6, edges: 2, held: 0, tmo: 1'b0});
        tick();
        checks++; if (BUSY !== 1'b1 || GNT_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_busy: got busy=%b valid=%b want 1/0", BUSY, GNT_VALID);
        end
        wait_grant(40, e);
        if (e >= 0) e++;
        x = exp_q.pop_front();
        checks++; if (e != x.edges) begin errors++; $display("FAIL basic_latency: got %0d want %0d", e, x.edges); end
        checks++; if (int'(GNT_ID) != x.id || GNT !== (ONE << x.id)) begin
            errors++; $display("FAIL basic_slot: got id=%0d gnt=%h want slot %0d", GNT_ID, GNT, x.id);
        end
        tick();
        checks++; if (GNT !== 16'h0020) begin errors++; $display("FAIL basic_stable: got %h want 0020", GNT); end
        REQ = '0;
        tick();
        checks++; if (GNT !== '0 || GNT_VALID !== 1'b0 || GNT_ID !== '0 || BUSY !== 1'b1) begin
            errors++; $display("FAIL basic_release: got gnt=%h valid=%b id=%0d busy=%b want 0/0/0/1", GNT, GNT_VALID, GNT_ID, BUSY);
        end
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy=%b want 0", BUSY); end
        // Pointer kept at 6 after release: slot 6 is granted without a rescan.
        REQ = 16'h0040;
        wait_grant(40, e);
        x = exp_q.pop_front();
        checks++; if (e != x.edges || int'(GNT_ID) != x.id) begin
            errors++; $display("FAIL basic_ptr_kept: got edges=%0d id=%0d want %0d/%0d", e, GNT_ID, x.edges, x.id);
        end
        REQ = '0;
        wait_release(20, e);
        tick();
    endtask

    task automatic test_timeout();
        exp_t x;
        int e;
        int h;
        bit pre;
        do_reset();
        EN  = 1'b1;
        REQ = 16'h0008;
        exp_q.push_back('{id: 3, edges: 5, held: MAX_HOLD, tmo: 1'b1});
        exp_q.push_back('{id: 3, edges: N + 1, held: MAX_HOLD, tmo: 1'b1});
        pre = 1'b0;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            if (pre) begin
                tick();
                checks++; if (TIMEOUT !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got %b want 0", TIMEOUT); end
            end
            wait_grant(60, e);
            if (pre && e >= 0) e++;
            checks++; if (e != x.edges) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", e, x.edges); end
            checks++; if (int'(GNT_ID) != x.id || GNT !== (ONE << x.id)) begin
                errors++; $display("FAIL tmo_slot: got id=%0d gnt=%h want slot %0d", GNT_ID, GNT, x.id);
            end
            wait_release(40, h);
            checks++; if (h != x.held) begin errors++; $display("FAIL tmo_hold: got %0d want %0d", h, x.held); end
            checks++; if (TIMEOUT !== x.tmo) begin errors++; $display("FAIL tmo_flag: got %b want %b", TIMEOUT, x.tmo); end
            pre = 1'b1;
        end
        REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_alternate();
        exp_t x;
        int e;
        int h;
        bit pre;
        do_reset();
        EN  = 1'b1;
        REQ = 16'h0208;
        exp_q.push_back('{id: 3, edges: 5,  held: MAX_HOLD, tmo: 1'b1});
        exp_q.push_back('{id: 9, edges: 7,  held: MAX_HOLD, tmo: 1'b1});
        exp_q.push_back('{id: 3, edges: 11, held: MAX_HOLD, tmo: 1'b1});
        pre = 1'b0;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            wait_grant(60, e);
            checks++; if (e != x.edges) begin errors++; $display("FAIL alt_gap: got %0d want %0d", e, x.edges); end
            checks++; if (int'(GNT_ID) != x.id || GNT !== (ONE << x.id)) begin
                errors++; $display("FAIL alt_slot: got id=%0d gnt=%h want slot %0d", GNT_ID, GNT, x.id);
            end
            wait_release(40, h);
            checks++; if (h != x.held || TIMEOUT !== x.tmo) begin
                errors++; $display("FAIL alt_hold: got hold=%0d tmo=%b want %0d/%b", h, TIMEOUT, x.held, x.tmo);
            end
            pre = 1'b1;
        end
        REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_en_gating();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int zeros;
        int edges;
        int e;
        do_reset();
        REQ   = 16'h8000;
        zeros = 0;
        edges = -1;
        for (int i = 0; i < 80; i++) begin
            EN = pat[i % 4];
            if (!EN) zeros++;
            tick();
            if (GNT_VALID === 1'b1) begin
                edges = i + 1;
                break;
            end
        end
        checks++; if (edges - zeros != N + 1 || edges < 0) begin
            errors++; $display("FAIL en_delay: got %0d enabled edges want %0d", edges - zeros, N + 1);
        end
        checks++; if (GNT !== 16'h8000 || GNT_ID !== 4'd15) begin
            errors++; $display("FAIL en_slot: got gnt=%h id=%0d want 8000/15", GNT, GNT_ID);
        end
        EN  = 1'b1;
        REQ = 16'h0001;
        wait_grant(10, e);
        checks++; if (e != 3 || GNT !== 16'h0001) begin
            errors++; $display("FAIL en_wrap: got edges=%0d gnt=%h want 3/0001", e, GNT);
        end
        REQ = '0;
        wait_release(20, e);
        tick();
    endtask

    task automatic test_async_reset();
        int e;
        do_reset();
        EN  = 1'b1;
        REQ = 16'h0004;
        wait_grant(20, e);
        checks++; if (e != 4 || GNT !== 16'h0004) begin
            errors++; $display("FAIL arst_pre: got edges=%0d gnt=%h want 4/0004", e, GNT);
        end
        #3 RST = 1'b1;
        #1;
        checks++; if (GNT !== '0 || GNT_VALID !== 1'b0 || BUSY !== 1'b0 || GNT_ID !== '0) begin
            errors++; $display("FAIL arst_clear: got gnt=%h valid=%b busy=%b id=%0d want 0", GNT, GNT_VALID, BUSY, GNT_ID);
        end
        #1 RST = 1'b0;
        wait_grant(40, e);
        checks++; if (e != 4 || GNT_ID !== 4'd2) begin
            errors++; $display("FAIL arst_restart: got edges=%0d id=%0d want 4/2", e, GNT_ID);
        end
        REQ = '0;
        wait_release(20, e);
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        EN  = 1'b1;
        REQ = 16'h0002;
        tick();
        tick();
        EN  = 1'b0;
        REQ = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (GNT_VALID !== 1'b0 || BUSY !== 1'b1) begin
                errors++; $display("FAIL sim_en_low: got valid=%b busy=%b want 0/1", GNT_VALID, BUSY);
            end
        end
        EN = 1'b1;
        tick();
        checks++; if (GNT_VALID !== 1'b1 || GNT_ID !== 4'd1) begin
            errors++; $display("FAIL sim_en_grant: got valid=%b id=%0d want 1/1", GNT_VALID, GNT_ID);
        end
        tick();
        tick();
        tick();
        checks++; if (GNT !== 16'h0002) begin errors++; $display("FAIL sim_at_max: got %h want 0002", GNT); end
        REQ = 16'h0001;
        tick();
        checks++; if (GNT_VALID !== 1'b0 || TIMEOUT !== 1'b0) begin
            errors++; $display("FAIL sim_drop_at_max: got valid=%b tmo=%b want 0/0", GNT_VALID, TIMEOUT);
        end
        REQ = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int wait_cnt [N];
        bit prev_gnt [N];
        int glen;
        int maxw;
        logic [N-1:0] gnt_before;
        do_reset();
        glen = 0;
        for (int b = 0; b < N; b++) begin
            wait_cnt[b] = 0;
            prev_gnt[b] = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            EN = (cyc < 3000) ? ($urandom_range(3) != 0) : 1'b1;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(23) == 0) REQ[b] = ~REQ[b];
            end
            gnt_before = GNT;
            tick();
            if (GNT_VALID) begin
                glen = (gnt_before == '0) ? 1 : glen + 1;
                checks++; if (glen > MAX_HOLD) begin errors++; $display("FAIL rnd_hold: got %0d want <= %0d", glen, MAX_HOLD); end
            end
            if (gnt_before != '0 && GNT == '0) begin
                checks++; if (TIMEOUT !== ((gnt_before & REQ) != '0)) begin
                    errors++; $display("FAIL rnd_release_kind: got tmo=%b want %b", TIMEOUT, (gnt_before & REQ) != '0);
                end
            end
            if (TIMEOUT) begin
                checks++; if (glen != MAX_HOLD) begin errors++; $display("FAIL rnd_tmo_len: got %0d want %0d", glen, MAX_HOLD); end
            end
            if (cyc >= 3000) begin
                maxw = 0;
                for (int b = 0; b < N; b++) begin
                    if (prev_gnt[b]) wait_cnt[b] = 0;
                    else if (REQ[b] && !GNT[b]) wait_cnt[b]++;
                    else wait_cnt[b] = 0;
                    prev_gnt[b] = GNT[b];
                    if (wait_cnt[b] > maxw) maxw = wait_cnt[b];
                end
                checks++; if (maxw > FAIR_BOUND) begin errors++; $display("FAIL rnd_starve: got wait %0d want <= %0d", maxw, FAIR_BOUND); end
            end
        end
        REQ = '0;
        EN  = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_timeout();
        test_alternate();
        test_en_gating();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
